game_sequencer: RTL
===================

Name: game_sequencer

Overview:
- Top-level play controller that sequences the falling-block datapath through one game: title, spawn, fall, lock, line-clear, game over.
- Drives the datapath's gamestate, reset_game, ResetShape, Score and speed_y inputs, and consumes its touchdown output.
- Generates the next piece id and holds the score.
- Sits between the keyboard decoder and the block-decision/board logic.

Parameters:
- SCORE_MAX, 9999, saturation ceiling for Score.
- LFSR_SEED, 8'h01, reset value of the piece LFSR (must be nonzero).
- CLEAR_TIMEOUT, 1023, decis_clk cycles to wait in CLEAR before forcing SPAWN.

Ports:
- decis_clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- keypress  in  3  key code: 0 none, 1 left, 2 right, 3 down, 4 drop, 5 start, 6 pause.
- touchdown  in  1  datapath reports the block has landed.
- spawn_blocked  in  1  board reports the spawn area is occupied.
- clear_done  in  1  one-cycle pulse from the board: row clear finished.
- lines_cleared  in  3  rows removed, 0..4; valid with clear_done.
- gamestate  out  2  0 TITLE, 1 PAUSED, 2 PLAY, 3 OVER.
- reset_game  out  1  held high while in TITLE.
- reset_shape  out  1  one-cycle pulse that respawns the block at start position.
- lock_req  out  1  one-cycle pulse: board must latch the current piece.
- piece_id  out  3  shape of the next block, 0..6.
- Score  out  14  running score, saturating.
- speed_y  out  28  fall period for the datapath.

Behaviour:
- Reset values:
  - FSM in S_TITLE; gamestate=0; reset_game=1.
  - reset_shape=0, lock_req=0, piece_id=0, Score=0, speed_y=28'h1ffffff.
  - LFSR=LFSR_SEED; key_prev=0; timeout counter=0.
- Start edge:
  - start_edge = (keypress==5) && (key_prev!=5).
  - key_prev is registered every cycle.
  - Pause edge is defined the same way for code 6.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances every cycle in every state except TITLE-with-Reset.
- FSM, all outputs registered:
  - S_TITLE (gs 0, reset_game=1): start_edge -> S_SPAWN; Score<=0 in the same cycle.
  - S_SPAWN (gs 2):
    - If spawn_blocked -> S_OVER.
    - Else reset_shape=1 for exactly this one cycle; piece_id <= (lfsr[2:0]==7) ? 0 : lfsr[2:0]; -> S_FALL.
  - S_FALL (gs 2): touchdown -> S_LOCK.
  - S_LOCK (gs 2): lock_req=1 for one cycle -> S_CLEAR.
  - S_CLEAR (gs 2):
    - clear_done -> Score <= min(Score+lines_cleared, SCORE_MAX); -> S_SPAWN.
    - If no clear_done within CLEAR_TIMEOUT cycles -> S_SPAWN, score unchanged.
  - S_OVER (gs 3): start_edge -> S_TITLE. Score is held until TITLE is left.
- Outputs per state:
  - reset_game=1 only in S_TITLE.
  - reset_shape and lock_req are never high in the same cycle.
  - Neither is ever high for more than one cycle.
- speed_y: registered from the Score of the previous cycle.

  | Score | speed_y |
  |---|---|
  | >=25 | 28'h04fffff |
  | >=20 | 28'h06fffff |
  | >=15 | 28'h08fffff |
  | >=10 | 28'h09fffff |
  | >=5 | 28'h0Afffff |
  | else | 28'h1ffffff |

- Simultaneous events:
  - touchdown in S_SPAWN is ignored.
  - clear_done outside S_CLEAR is ignored.
  - lines_cleared values >4 are clamped to 4.
- Reset mid-game: asynchronous return to the reset state from any state; no pulse outputs are emitted.

Optional Feature:
- GAME_SEQ_PAUSE_EN defined:
  - Pause edge in S_FALL -> S_PAUSED (gs 1); the FALL context is held.
  - Next pause edge -> S_FALL.
  - start_edge in S_PAUSED -> S_TITLE.
  - In S_PAUSED the datapath is frozen because gamestate!=2.
- Undefined: code 6 is ignored, S_PAUSED is unreachable, and gamestate is never 1.

Decomposition:
- Package game_pkg holds:
  - gamestate_e (TITLE/PAUSED/PLAY/OVER).
  - key_e codes 0..6.
  - seq_state_e.
  - Speed threshold/period constants.
- Sub-module piece_lfsr (8-bit LFSR with seed parameter, enable, 3-bit mapped id output) is natural and reused by the preview logic.

Test Plan:
- Reset, then keypress 0->5 -> gamestate 0->2 on the next edge; reset_shape single pulse one cycle later; Score=0.
- Hold keypress=5 for 10 cycles in S_OVER -> exactly one transition to TITLE; no repeated toggling.
- In FALL, touchdown=1 -> lock_req pulse next cycle. Then clear_done with lines_cleared=3 -> Score 3, then reset_shape pulse, piece_id in 0..6.
- Preload Score to 4, clear 1 line -> Score 5 and speed_y=28'h0Afffff one cycle later. From Score 9998, clear 4 lines -> Score 9999.
- spawn_blocked=1 at SPAWN -> gamestate=3, no reset_shape pulse.
- Reset asserted during S_LOCK -> outputs at reset values immediately (async); with GAME_SEQ_PAUSE_EN, pause in FALL -> gamestate=1, second pause -> gamestate=2.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the falling-block play controller.
//   gamestate_e  : encoding of the gamestate output seen by the datapath
//   key_e        : keyboard decoder codes
//   seq_state_e  : sequencer FSM states
//   speed_for_score() : fall period lookup from the running score
package game_pkg;

    typedef enum logic [1:0] {
        GS_TITLE  = 2'd0,
        GS_PAUSED = 2'd1,
        GS_PLAY   = 2'd2,
        GS_OVER   = 2'd3
    } gamestate_e;

    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_LEFT  = 3'd1,
        KEY_RIGHT = 3'd2,
        KEY_DOWN  = 3'd3,
        KEY_DROP  = 3'd4,
        KEY_START = 3'd5,
        KEY_PAUSE = 3'd6
    } key_e;

    typedef enum logic [2:0] {
        S_TITLE  = 3'd0,
        S_SPAWN  = 3'd1,
        S_FALL   = 3'd2,
        S_LOCK   = 3'd3,
        S_CLEAR  = 3'd4,
        S_OVER   = 3'd5,
        S_PAUSED = 3'd6
    } seq_state_e;

    localparam logic [13:0] SPEED_TH_L5 = 14'd25;
    localparam logic [13:0] SPEED_TH_L4 = 14'd20;
    localparam logic [13:0] SPEED_TH_L3 = 14'd15;
    localparam logic [13:0] SPEED_TH_L2 = 14'd10;
    localparam logic [13:0] SPEED_TH_L1 = 14'd5;

    localparam logic [27:0] SPEED_P_L5 = 28'h04fffff;
    localparam logic [27:0] SPEED_P_L4 = 28'h06fffff;
    localparam logic [27:0] SPEED_P_L3 = 28'h08fffff;
    localparam logic [27:0] SPEED_P_L2 = 28'h09fffff;
    localparam logic [27:0] SPEED_P_L1 = 28'h0afffff;
    localparam logic [27:0] SPEED_P_L0 = 28'h1ffffff;

    // Higher score -> shorter fall period.
    function automatic logic [27:0] speed_for_score(input logic [13:0] score);
        if (score >= SPEED_TH_L5)      return SPEED_P_L5;
        else if (score >= SPEED_TH_L4) return SPEED_P_L4;
        else if (score >= SPEED_TH_L3) return SPEED_P_L3;
        else if (score >= SPEED_TH_L2) return SPEED_P_L2;
        else if (score >= SPEED_TH_L1) return SPEED_P_L1;
        else                           return SPEED_P_L0;
    endfunction

endpackage

// File: rtl/piece_lfsr.sv
// piece_lfsr: 8-bit Fibonacci LFSR (taps 8,6,5,4) producing a piece id 0..6.
//   clk, rst : clock, asynchronous active-high reset (loads SEED)
//   en       : advance one step this cycle
//   id       : low three bits of the register, with 7 folded onto 0
module piece_lfsr #(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [2:0] id
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign id = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: play controller sequencing one game of the falling-block
// datapath (title, spawn, fall, lock, line clear, game over).
//   decis_clk, Reset : clock, asynchronous active-high reset
//   keypress         : decoded key code (5 start, 6 pause)
//   touchdown        : datapath says the block landed
//   spawn_blocked    : board says the spawn area is occupied
//   clear_done       : one-cycle pulse, row clear finished; lines_cleared valid
//   gamestate        : 0 title, 1 paused, 2 play, 3 over
//   reset_game       : high while in title
//   reset_shape      : one-cycle respawn pulse
//   lock_req         : one-cycle request to latch the current piece
//   piece_id         : shape of the next block, 0..6
//   Score            : saturating score
//   speed_y          : fall period, follows the previous cycle's Score
// Build option: define GAME_SEQ_PAUSE_EN to enable the pause key.
//
// state    | meaning
// S_TITLE  | title screen, datapath held in reset
// S_SPAWN  | respawn block or detect game over
// S_FALL   | block falling under datapath control
// S_LOCK   | ask the board to latch the landed piece
// S_CLEAR  | wait for the board to finish clearing rows (with timeout)
// S_OVER   | game over, score shown until restart
// S_PAUSED | fall frozen (only with GAME_SEQ_PAUSE_EN)
module game_sequencer
    import game_pkg::*;
#(
    parameter int         SCORE_MAX     = 9999,
    parameter logic [7:0] LFSR_SEED     = 8'h01,
    parameter int         CLEAR_TIMEOUT = 1023
) (
    input  logic        decis_clk,
    input  logic        Reset,
    input  logic [2:0]  keypress,
    input  logic        touchdown,
    input  logic        spawn_blocked,
    input  logic        clear_done,
    input  logic [2:0]  lines_cleared,
    output logic [1:0]  gamestate,
    output logic        reset_game,
    output logic        reset_shape,
    output logic        lock_req,
    output logic [2:0]  piece_id,
    output logic [13:0] Score,
    output logic [27:0] speed_y
);

    localparam int              CNT_W      = $clog2(CLEAR_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CLEAR_TIMEOUT - 1);
    localparam logic [14:0]     SCORE_CAP15 = 15'(SCORE_MAX);
    localparam logic [13:0]     SCORE_CAP14 = 14'(SCORE_MAX);

    seq_state_e       state_q, state_d;
    logic [2:0]       key_prev_q, key_prev_d;
    logic [1:0]       gamestate_q, gamestate_d;
    logic             reset_game_q, reset_game_d;
    logic             reset_shape_q, reset_shape_d;
    logic             lock_req_q, lock_req_d;
    logic [2:0]       piece_id_q, piece_id_d;
    logic [13:0]      score_q, score_d;
    logic [27:0]      speed_q, speed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             start_edge;
    logic [2:0]       lines_clamped;
    logic [14:0]      score_sum;
    logic [2:0]       lfsr_id;

    // Runs freely; the async reset alone returns it to the seed.
    piece_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (decis_clk),
        .rst (Reset),
        .en  (1'b1),
        .id  (lfsr_id)
    );

    assign start_edge    = (keypress == KEY_START) && (key_prev_q != KEY_START);
    assign lines_clamped = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
    assign score_sum     = 15'(score_q) + 15'(lines_clamped);

`ifdef GAME_SEQ_PAUSE_EN
    logic pause_edge;
    assign pause_edge = (keypress == KEY_PAUSE) && (key_prev_q != KEY_PAUSE);
`endif

    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        piece_id_d    = piece_id_q;
        cnt_d         = cnt_q;
        reset_shape_d = 1'b0;
        lock_req_d    = 1'b0;
        key_prev_d    = keypress;
        speed_d       = speed_for_score(score_q);

        case (state_q)
            S_TITLE: begin
                if (start_edge) begin
                    state_d = S_SPAWN;
                    score_d = '0;
                end
            end
            S_SPAWN: begin
                if (spawn_blocked) begin
                    state_d = S_OVER;
                end else begin
                    reset_shape_d = 1'b1;
                    piece_id_d    = lfsr_id;
                    state_d       = S_FALL;
                end
            end
            S_FALL: begin
`ifdef GAME_SEQ_PAUSE_EN
                if (pause_edge)     state_d = S_PAUSED;
                else if (touchdown) state_d = S_LOCK;
`else
                if (touchdown) state_d = S_LOCK;
`endif
            end
            S_LOCK: begin
                lock_req_d = 1'b1;
                cnt_d      = CNT_LOAD;
                state_d    = S_CLEAR;
            end
            S_CLEAR: begin
                // A clear_done on the final timeout cycle still scores.
                if (clear_done) begin
                    score_d = (score_sum > SCORE_CAP15) ? SCORE_CAP14 : score_sum[13:0];
                    cnt_d   = '0;
                    state_d = S_SPAWN;
                end else if (cnt_q == '0) begin
                    state_d = S_SPAWN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_OVER: begin
                if (start_edge) state_d = S_TITLE;
            end
            S_PAUSED: begin
`ifdef GAME_SEQ_PAUSE_EN
                if (start_edge)      state_d = S_TITLE;
                else if (pause_edge) state_d = S_FALL;
`else
                state_d = S_TITLE;
`endif
            end
            default: state_d = S_TITLE;
        endcase

        // Level outputs are registered from the next state so they line up
        // with the state register.
        case (state_d)
            S_TITLE:  gamestate_d = GS_TITLE;
            S_OVER:   gamestate_d = GS_OVER;
            S_PAUSED: gamestate_d = GS_PAUSED;
            default:  gamestate_d = GS_PLAY;
        endcase
        reset_game_d = (state_d == S_TITLE);
    end

    always_ff @(posedge decis_clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_TITLE;
            key_prev_q    <= '0;
            gamestate_q   <= GS_TITLE;
            reset_game_q  <= 1'b1;
            reset_shape_q <= 1'b0;
            lock_req_q    <= 1'b0;
            piece_id_q    <= '0;
            score_q       <= '0;
            speed_q       <= SPEED_P_L0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            key_prev_q    <= key_prev_d;
            gamestate_q   <= gamestate_d;
            reset_game_q  <= reset_game_d;
            reset_shape_q <= reset_shape_d;
            lock_req_q    <= lock_req_d;
            piece_id_q    <= piece_id_d;
            score_q       <= score_d;
            speed_q       <= speed_d;
            cnt_q         <= cnt_d;
        end
    end

    assign gamestate   = gamestate_q;
    assign reset_game  = reset_game_q;
    assign reset_shape = reset_shape_q;
    assign lock_req    = lock_req_q;
    assign piece_id    = piece_id_q;
    assign Score       = score_q;
    assign speed_y     = speed_q;

endmodule
